// File: rtl/vdp18_clk_en_div.sv
// Multi-channel clock-enable divider with glitch-free divisor updates.
// Define VDP18_CLK_EN_DIV_ALIGN_EN to generate the common-wrap marker align_o.
module vdp18_clk_en_div #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 4,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {4'd4, 4'd3, 4'd2}
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clk_en_i,
    input  logic                    sync_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH*DIV_W-1:0] phase_i,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH*DIV_W-1:0] div_o,
    output logic                    align_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic              fire;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] hit;

    // Outputs stay low while reset is held, even if the master enable toggles.
    assign fire = reset_n_i & clk_en_i & ~sync_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_p;
        logic [DIV_W-1:0] div_req;
        logic [DIV_W-1:0] phase;

        assign div_req = div_i[k*DIV_W +: DIV_W];
        assign phase   = phase_i[k*DIV_W +: DIV_W];
        assign wrap[k] = (cnt_q == div_q - ONE);
        assign hit[k]  = (cnt_q == phase);

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q <= '0;
                div_q <= DIV_INIT[k*DIV_W +: DIV_W];
                div_p <= DIV_INIT[k*DIV_W +: DIV_W];
            end else begin
                // A zero divisor request is treated as divide-by-one.
                div_p <= (div_req == '0) ? ONE : div_req;
                if (sync_i) begin
                    cnt_q <= '0;
                    div_q <= div_p;
                end else if (clk_en_i) begin
                    if (wrap[k]) begin
                        cnt_q <= '0;
                        div_q <= div_p;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            end
        end

        assign div_o[k*DIV_W +: DIV_W] = div_q;
    end

    assign clk_en_o = {NUM_CH{fire}} & hit;

`ifdef VDP18_CLK_EN_DIV_ALIGN_EN
    assign align_o = fire & (&wrap);
`else
    assign align_o = 1'b0;
`endif

endmodule

// File: tb/tb_vdp18_clk_en_div.sv
// Directed and randomized bench for vdp18_clk_en_div against a cycle model.
// Align expectations follow VDP18_CLK_EN_DIV_ALIGN_EN.
module tb_vdp18_clk_en_div;

    localparam logic [11:0] INIT = {4'd4, 4'd3, 4'd2};
`ifdef VDP18_CLK_EN_DIV_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        clk_en_i = 1'b0;
    logic        sync_i = 1'b0;
    logic [11:0] div_i = INIT;
    logic [11:0] phase_i = {4'd3, 4'd2, 4'd1};
    logic [2:0]  clk_en_o;
    logic [11:0] div_o;
    logic        align_o;

    int checks = 0;
    int failures = 0;

    int mcnt [3];
    int mdiv [3];
    int mdivp[3];

    vdp18_clk_en_div dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clk_en_i (clk_en_i),
        .sync_i   (sync_i),
        .div_i    (div_i),
        .phase_i  (phase_i),
        .clk_en_o (clk_en_o),
        .div_o    (div_o),
        .align_o  (align_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int fld(input logic [11:0] v, input int k);
        return int'(v[k*4 +: 4]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k]  = 0;
            mdiv[k]  = fld(INIT, k);
            mdivp[k] = fld(INIT, k);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk_i cycle: drive, check combinational outputs, advance the model.
    task automatic tick(input logic en, input logic sy,
                        output logic [2:0] ce, output logic al);
        logic [2:0]  exp_ce;
        logic [11:0] exp_div;
        logic        all_wrap;
        int          req;
        clk_en_i = en;
        sync_i   = sy;
        #1;
        all_wrap = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_ce[k] = en && !sy && (mcnt[k] == fld(phase_i, k));
            if (mcnt[k] != mdiv[k] - 1) all_wrap = 1'b0;
            exp_div[k*4 +: 4] = 4'(mdiv[k]);
        end
        chk("clk_en_o", 32'(clk_en_o), 32'(exp_ce));
        chk("div_o", 32'(div_o), 32'(exp_div));
        chk("align_o", 32'(align_o), 32'(ALIGN && en && !sy && all_wrap));
        ce = clk_en_o;
        al = align_o;
        @(posedge clk_i);
        for (int k = 0; k < 3; k++) begin
            req = fld(div_i, k);
            if (sy) begin
                mcnt[k] = 0;
                mdiv[k] = mdivp[k];
            end else if (en) begin
                if (mcnt[k] == mdiv[k] - 1) begin
                    mcnt[k] = 0;
                    mdiv[k] = mdivp[k];
                end else begin
                    mcnt[k]++;
                end
            end
            mdivp[k] = (req == 0) ? 1 : req;
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [2:0] ce;
        logic       al;
        int         n;
        int         zero_hits;
        int         pulses[$];
        int         first[3];

        model_reset();
        #12;
        chk("reset_clk_en", 32'(clk_en_o), 32'd0);
        chk("reset_div", 32'(div_o), 32'(INIT));
        chk("reset_align", 32'(align_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Default profile: enable 1 cycle in 3, 24 enables.
        n = 0;
        for (int c = 0; c < 72; c++) begin
            tick(c % 3 == 2, 1'b0, ce, al);
            if (c % 3 == 2) begin
                n++;
                chk("prof_ch0", 32'(ce[0]), 32'(n % 2 == 0));
                chk("prof_ch1", 32'(ce[1]), 32'(n % 3 == 0));
                chk("prof_ch2", 32'(ce[2]), 32'(n % 4 == 0));
                chk("prof_align", 32'(al), 32'(ALIGN && n % 12 == 0));
            end
        end

        // Divisor change on ch1 mid-period.
        phase_i = {4'd3, 4'd0, 4'd1};
        tick(1'b1, 1'b0, ce, al);
        div_i = {4'd4, 4'd5, 4'd2};
        for (int i = 1; i <= 13; i++) begin
            tick(1'b1, 1'b0, ce, al);
            if (ce[1]) pulses.push_back(i);
        end
        chk("divchg_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            chk("divchg_p0", 32'(pulses[0]), 32'd3);
            chk("divchg_p1", 32'(pulses[1]), 32'd8);
            chk("divchg_p2", 32'(pulses[2]), 32'd13);
        end
        chk("divchg_div_o", 32'(div_o[7:4]), 32'd5);

        // Sync on an enable cycle with ch0 about to fire.
        div_i   = INIT;
        phase_i = {4'd3, 4'd2, 4'd1};
        tick(1'b0, 1'b0, ce, al);
        tick(1'b0, 1'b1, ce, al);
        tick(1'b1, 1'b0, ce, al);
        tick(1'b1, 1'b1, ce, al);
        chk("sync_no_pulse", 32'(ce), 32'd0);
        tick(1'b1, 1'b0, ce, al);
        chk("sync_next1", 32'(ce[0]), 32'd0);
        tick(1'b1, 1'b0, ce, al);
        chk("sync_next2", 32'(ce[0]), 32'd1);

        // Divisor 0 (as 1) with phase 0 on ch2, phase 5 > div 4 on ch0.
        div_i   = {4'd0, 4'd3, 4'd4};
        phase_i = {4'd0, 4'd0, 4'd5};
        tick(1'b0, 1'b0, ce, al);
        tick(1'b0, 1'b1, ce, al);
        n = 0;
        zero_hits = 0;
        for (int c = 0; c < 400 && n < 40; c++) begin
            logic en;
            en = 1'($urandom % 2);
            tick(en, 1'b0, ce, al);
            if (en) n++;
            if (ce[0]) zero_hits++;
            if (c % 8 == 0) chk("div1_follow", 32'(ce[2]), 32'(en));
        end
        chk("div1_enables", 32'(n), 32'd40);
        chk("phase_disable", 32'(zero_hits), 32'd0);

        // Asynchronous reset between edges while ch0 is firing.
        div_i   = INIT;
        phase_i = {4'd3, 4'd2, 4'd1};
        tick(1'b0, 1'b0, ce, al);
        tick(1'b0, 1'b1, ce, al);
        tick(1'b1, 1'b0, ce, al);
        clk_en_i = 1'b1;
        #2;
        chk("pre_reset_fire", 32'(clk_en_o[0]), 32'd1);
        reset_n_i = 1'b0;
        #1;
        chk("async_clk_en", 32'(clk_en_o), 32'd0);
        chk("async_div", 32'(div_o), 32'(INIT));
        chk("async_align", 32'(align_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        clk_en_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        first = '{0, 0, 0};
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0, ce, al);
            for (int k = 0; k < 3; k++)
                if (ce[k] && first[k] == 0) first[k] = i;
        end
        chk("post_reset_ch0", 32'(first[0]), 32'd2);
        chk("post_reset_ch1", 32'(first[1]), 32'd3);
        chk("post_reset_ch2", 32'(first[2]), 32'd4);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom % 16 == 0) div_i = 12'($urandom);
            if ($urandom % 16 == 0) phase_i = 12'($urandom);
            tick(1'($urandom % 2), ($urandom % 20) == 0, ce, al);
        end
        div_i = 12'h111;
        phase_i = 12'h000;
        tick(1'b0, 1'b0, ce, al);
        tick(1'b0, 1'b1, ce, al);
        for (int c = 0; c < 8; c++) begin
            tick(1'b1, 1'b0, ce, al);
            chk("all_div1", 32'({ce, al}), 32'({3'b111, ALIGN}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
